tp_period_store: RTL and testbench
==================================

// Module: tp_period_store
// PURPOSE
// Downstream of the application FSM: owns the 4-digit BCD pulse-period setting edited from the front panel.
// Turns the FSM's tp_* control strobes into digit edits on a working copy, commits or discards that copy,
// converts the committed value to binary milliseconds for the pulse generator, and drives display/blink data.
// PARAMETERS
// DEFAULT_BCD   16'h0100  committed period after reset (4 BCD digits, d3..d0 = 0100 -> 100 ms)
// BLINK_MS      249       timebase ticks per blink half-period (250 ms on / 250 ms off)
// PORTS
// clk            in   1   system clock, rising edge
// reset_n        in   1   asynchronous, active-low reset
// timebase       in   1   1 ms single-cycle tick
// edit_mode      in   1   high while the FSM is in the set-pulse-mode state (level)
// tp_selected    in   3   selected digit, 0 = d0 (ms units) .. 3 = d3; values 4..7 are ignored
// tp_adj         in   1   edit direction: 1 = increment, 0 = decrement
// tp_edit_enable in   1   edit request; acted on at its rising edge only
// tp_save        in   1   commit request; acted on at its rising edge only
// tp_temp_sync   in   1   reload working copy from committed; acted on at its rising edge only
// work_bcd       out  16  working-copy digits {d3,d2,d1,d0}, shown on the display
// blank_mask     out  4   1 = blank that digit this cycle (blink of the selected digit)
// period_ms      out  14  committed period in binary ms (1..9999)
// period_valid   out  1   period_ms is stable; low while a conversion is running
// commit_reject  out  1   single-cycle pulse: commit refused because the working copy is 0000
// BEHAVIOUR
// Reset values: work_bcd=DEFAULT_BCD; committed=DEFAULT_BCD; period_ms=binary(DEFAULT_BCD); period_valid=1;
//   blank_mask=0; commit_reject=0; blink counter=0, blink phase=on; edge-detect history regs = 1.
//   Because the history regs reset to 1, a strobe held high out of reset does not count as an edge.
// Edge detection: each strobe is registered once; event = in & ~prev. Inputs are synchronous to clk.
// Event priority within one cycle: temp_sync > save > edit. A lower-priority event in the same cycle is dropped.
// temp_sync: work_bcd <= committed on the next edge.
// edit: applies only when edit_mode=1 and tp_selected<=3; otherwise ignored.
//   Operates on digit[tp_selected] only. Inc wraps 9->0, dec wraps 0->9; no carry or borrow into other digits.
// save: if work_bcd==16'h0000, committed is unchanged and commit_reject pulses for one cycle.
//   Otherwise committed <= work_bcd and the converter starts.
// Discard (ESC): no strobe at all. The working copy is overwritten by the next temp_sync.
// Converter states: IDLE -> CONV (4 iterations, d3 first: acc = (acc<<3)+(acc<<1)+digit) -> IDLE.
//   Width: 14-bit accumulator; the maximum is 9999, so it never overflows.
//   Timing: save event sampled in cycle N; committed updated N+1; period_valid low N+1..N+4.
//   period_ms updated and period_valid=1 at N+5. period_ms keeps its old value until that update.
//   A save during CONV restarts the conversion from the new committed value. Only the latest commit is output.
// Blink: when edit_mode=1, the counter counts timebase ticks. On reaching BLINK_MS it reloads 0 and toggles phase.
//   blank_mask = onehot(tp_selected) when phase=off; 0 when phase=on.
//   When edit_mode=0: blank_mask=0, counter held at 0, phase=on.
//   On edit_mode 0->1 the selected digit starts visible.
// Reset mid-conversion: the async reset wins; outputs return to the reset values above.
// Illegal BCD: digit values A..F never arise (writes are checked). If a digit holds A..F, inc or dec loads 0.
// STRUCTURE
// Shared package/include: the BCD digit width, the converter state encoding, DEFAULT_BCD, and the
//   onehot(selected) decode shared with the display mux.
// Sub-module: tp_bcd2bin (iterative 4-digit BCD->binary, start/busy/done handshake, 14-bit result).
//   Top level contains: edge detectors, edit datapath, committed register, blink timer, commit-reject logic.
// TESTING
// Reset with tp_save=1, tp_temp_sync=1 held -> no edge; period_ms=100, valid=1, work_bcd=16'h0100.
// temp_sync edge; edit_mode=1, sel=0, inc x3 -> work=16'h0103; save -> valid low 4 cycles, then period_ms=103.
// sel=0, work d0=9, inc -> d0=0, d1 unchanged. sel=3, d3=0, dec -> d3=9, other digits unchanged.
// work=0000, save edge -> commit_reject 1-cycle pulse; committed and period_ms unchanged; valid stays 1.
// temp_sync and edit in the same cycle -> work=committed, edit lost. Second save 2 cycles after the first -> final period = 2nd value.
// edit_mode=1, sel=2, 1000 timebase ticks -> blank_mask toggles 0000/0100 every 250 ticks; edit_mode=0 -> 0000.

Source files
------------

// File: rtl/tp_period_store_pkg.sv
// ---------------------------------------------------------------------------
// tp_period_store_pkg
// Shared definitions for the pulse-period store and its BCD->binary converter:
// digit/field widths, the power-on period, the converter state encoding, the
// digit-select one-hot decode used by the display mux, and the digit
// increment/decrement rule used by the edit datapath.
// ---------------------------------------------------------------------------
package tp_period_store_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = DIGIT_W * NUM_DIGITS;
  localparam int MS_W       = 14;  // 9999 < 2**14

  // Committed period after reset: d3..d0 = 0,1,0,0 -> 100 ms.
  localparam logic [BCD_W-1:0] DEFAULT_BCD = 16'h0100;

  // Converter state encoding.
  localparam logic [0:0] CONV_IDLE = 1'b0;
  localparam logic [0:0] CONV_RUN  = 1'b1;

  // One-hot digit select; selections 4..7 decode to no digit at all.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [2:0] sel);
    digit_onehot = '0;
    if (!sel[2]) digit_onehot[sel[1:0]] = 1'b1;
  endfunction

  // Single-digit edit: wraps 9->0 / 0->9 with no carry. A non-BCD digit
  // (A..F) is forced back to 0 whichever way it is edited.
  function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] d,
                                                    input logic inc);
    if (d > 4'd9)  digit_step = 4'd0;
    else if (inc)  digit_step = (d == 4'd9) ? 4'd0 : d + 4'd1;
    else           digit_step = (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Elaboration-time conversion, used only to derive the reset value of the
  // binary period from DEFAULT_BCD.
  function automatic logic [MS_W-1:0] bcd4_to_bin(input logic [BCD_W-1:0] bcd);
    logic [MS_W-1:0] acc;
    acc = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc = (acc * 14'd10) + {10'd0, bcd[i*DIGIT_W +: DIGIT_W]};
    end
    return acc;
  endfunction

  localparam logic [MS_W-1:0] DEFAULT_MS = bcd4_to_bin(DEFAULT_BCD);

endpackage

// File: rtl/tp_period_store_bcd2bin.sv
// ---------------------------------------------------------------------------
// tp_bcd2bin
// Iterative 4-digit BCD -> binary converter, most significant digit first:
// acc = acc*10 + digit, with acc*10 formed as (acc<<3)+(acc<<1).
// A start pulse loads the operand (and restarts a conversion in progress);
// four iteration cycles follow, the last of which flags done while result
// carries the finished value for the parent to capture.
//
// Ports
//   clk      in   1   system clock
//   reset_n  in   1   asynchronous active-low reset
//   start    in   1   load bcd and begin (restart) a conversion
//   bcd      in  16   {d3,d2,d1,d0} operand, sampled with start
//   busy     out  1   conversion in progress
//   done     out  1   final iteration this cycle; result is valid now
//   result   out 14   converted value, meaningful while done is high
// ---------------------------------------------------------------------------
module tp_bcd2bin
  import tp_period_store_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd,
  output logic             busy,
  output logic             done,
  output logic [MS_W-1:0]  result
);

  logic [0:0]       state;
  logic [1:0]       iter;
  logic [BCD_W-1:0] digits;   // operand, shifted left one digit per iteration
  logic [MS_W-1:0]  acc;
  logic [MS_W-1:0]  acc_next;

  assign acc_next = (acc << 3) + (acc << 1) + {10'd0, digits[BCD_W-1 -: DIGIT_W]};
  assign busy     = (state == CONV_RUN);
  // A restart in the final cycle supersedes the result being finished.
  assign done     = busy && (iter == 2'd3) && !start;
  assign result   = acc_next;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= CONV_IDLE;
      iter   <= '0;
      digits <= '0;
      acc    <= '0;
    end else if (start) begin
      state  <= CONV_RUN;
      iter   <= '0;
      digits <= bcd;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_next;
      digits <= {digits[BCD_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
      iter   <= iter + 2'd1;
      if (iter == 2'd3) state <= CONV_IDLE;
    end
  end

endmodule

// File: rtl/tp_period_store.sv
// ---------------------------------------------------------------------------
// tp_period_store
// Owns the 4-digit BCD pulse-period setting edited from the front panel.
// The FSM's strobes are edge-detected (temp_sync > save > edit), edits
// change one digit of a working copy, save commits a non-zero working copy
// and starts conversion to binary milliseconds, and a blink timer blanks the
// selected digit on alternate 250 ms half-periods while editing.
//
// Ports
//   clk             in   1   system clock
//   reset_n         in   1   asynchronous active-low reset
//   timebase        in   1   1 ms single-cycle tick
//   edit_mode       in   1   FSM is in set-pulse-mode (level)
//   tp_selected     in   3   selected digit 0..3 (4..7 ignored)
//   tp_adj          in   1   1 = increment, 0 = decrement
//   tp_edit_enable  in   1   edit strobe (rising edge)
//   tp_save         in   1   commit strobe (rising edge)
//   tp_temp_sync    in   1   reload working copy strobe (rising edge)
//   work_bcd        out 16   working-copy digits {d3,d2,d1,d0}
//   blank_mask      out  4   1 = blank that digit this cycle
//   period_ms       out 14   committed period in binary ms
//   period_valid    out  1   low while a conversion is running
//   commit_reject   out  1   one-cycle pulse: commit of 0000 refused
// ---------------------------------------------------------------------------
module tp_period_store
  import tp_period_store_pkg::*;
#(
  parameter int BLINK_MS = 249
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  timebase,
  input  logic                  edit_mode,
  input  logic [2:0]            tp_selected,
  input  logic                  tp_adj,
  input  logic                  tp_edit_enable,
  input  logic                  tp_save,
  input  logic                  tp_temp_sync,
  output logic [BCD_W-1:0]      work_bcd,
  output logic [NUM_DIGITS-1:0] blank_mask,
  output logic [MS_W-1:0]       period_ms,
  output logic                  period_valid,
  output logic                  commit_reject
);

  localparam int BLINK_W = $clog2(BLINK_MS + 1);

  // Strobe history. Resetting to 1 means a strobe already high when reset
  // releases is not mistaken for a fresh request.
  logic ts_prev, save_prev, edit_prev;
  logic ts_raw, save_raw, edit_raw;
  logic ts_evt, save_evt, edit_evt;
  logic edit_apply, work_zero, commit_ok;

  logic [BCD_W-1:0]   committed;
  logic [DIGIT_W-1:0] sel_digit;

  logic               conv_busy, conv_done;
  logic [MS_W-1:0]    conv_result;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  assign ts_raw   = tp_temp_sync   & ~ts_prev;
  assign save_raw = tp_save        & ~save_prev;
  assign edit_raw = tp_edit_enable & ~edit_prev;

  // Priority: a lower-priority request arriving with a higher one is dropped.
  assign ts_evt   = ts_raw;
  assign save_evt = save_raw & ~ts_raw;
  assign edit_evt = edit_raw & ~save_raw & ~ts_raw;

  assign edit_apply = edit_evt & edit_mode & ~tp_selected[2];
  assign sel_digit  = work_bcd[{tp_selected[1:0], 2'b00} +: DIGIT_W];
  assign work_zero  = (work_bcd == '0);
  assign commit_ok  = save_evt & ~work_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_prev   <= 1'b1;
      save_prev <= 1'b1;
      edit_prev <= 1'b1;
    end else begin
      ts_prev   <= tp_temp_sync;
      save_prev <= tp_save;
      edit_prev <= tp_edit_enable;
    end
  end

  // Working copy and committed value. Discarding an edit needs no action:
  // the next temp_sync simply overwrites the working copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_bcd      <= DEFAULT_BCD;
      committed     <= DEFAULT_BCD;
      commit_reject <= 1'b0;
    end else begin
      if (ts_evt)
        work_bcd <= committed;
      else if (edit_apply)
        work_bcd[{tp_selected[1:0], 2'b00} +: DIGIT_W] <= digit_step(sel_digit, tp_adj);

      if (commit_ok) committed <= work_bcd;
      commit_reject <= save_evt & work_zero;
    end
  end

  // The converter is fed the value being committed in the same cycle, so it
  // sees exactly what lands in the committed register.
  tp_bcd2bin u_bcd2bin (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (commit_ok),
    .bcd     (work_bcd),
    .busy    (conv_busy),
    .done    (conv_done),
    .result  (conv_result)
  );

  // period_ms holds the previous value until a conversion completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       period_ms <= DEFAULT_MS;
    else if (conv_done) period_ms <= conv_result;
  end

  assign period_valid = ~conv_busy;

  // Blink timer: runs only in edit mode, so entering edit mode always starts
  // with the selected digit visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!edit_mode) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (timebase) begin
      if (blink_cnt == BLINK_W'(BLINK_MS)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Gated by edit_mode directly so blanking stops the cycle edit mode drops.
  assign blank_mask = (edit_mode && !blink_on) ? digit_onehot(tp_selected) : '0;

endmodule

// File: tb/tb_tp_period_store.sv
// ---------------------------------------------------------------------------
// tb_tp_period_store
// Directed stimulus against tp_period_store. A behavioural model tracks the
// working digits, committed value, conversion countdown and blink tick count
// in plain arithmetic; one process compares every output after every clock.
// Literal expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_tp_period_store;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        timebase;
  logic        edit_mode;
  logic [2:0]  tp_selected;
  logic        tp_adj;
  logic        tp_edit_enable;
  logic        tp_save;
  logic        tp_temp_sync;
  logic [15:0] work_bcd;
  logic [3:0]  blank_mask;
  logic [13:0] period_ms;
  logic        period_valid;
  logic        commit_reject;

  tp_period_store dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .timebase       (timebase),
    .edit_mode      (edit_mode),
    .tp_selected    (tp_selected),
    .tp_adj         (tp_adj),
    .tp_edit_enable (tp_edit_enable),
    .tp_save        (tp_save),
    .tp_temp_sync   (tp_temp_sync),
    .work_bcd       (work_bcd),
    .blank_mask     (blank_mask),
    .period_ms      (period_ms),
    .period_valid   (period_valid),
    .commit_reject  (commit_reject)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_work[4];
  logic [3:0] m_comm[4];
  int         m_period, m_pend_val, m_pend_cnt, m_ticks;
  logic       m_valid, m_reject;
  logic       p_ts, p_sv, p_ed;
  bit         m_live = 1'b0;

  function automatic int work_value();
    return int'(m_work[3]) * 1000 + int'(m_work[2]) * 100 + int'(m_work[1]) * 10 + int'(m_work[0]);
  endfunction

  task automatic model_step();
    logic ts_e, sv_r, ed_r;
    int   d, nd, s;
    if (!reset_n) begin
      m_work = '{4'd0, 4'd0, 4'd1, 4'd0};   // index 0 = d0 -> 0100
      m_comm = '{4'd0, 4'd0, 4'd1, 4'd0};
      m_period = 100; m_valid = 1'b1; m_reject = 1'b0;
      m_pend_cnt = 0; m_pend_val = 0; m_ticks = 0;
      p_ts = 1'b1; p_sv = 1'b1; p_ed = 1'b1;
      m_live = 1'b1;
      return;
    end
    ts_e = tp_temp_sync & ~p_ts;
    sv_r = tp_save & ~p_sv;
    ed_r = tp_edit_enable & ~p_ed;
    m_reject = 1'b0;

    // Conversion takes four cycles after the commit edge.
    if (m_pend_cnt > 0) begin
      m_pend_cnt--;
      if (m_pend_cnt == 0) begin
        m_period = m_pend_val;
        m_valid  = 1'b1;
      end
    end

    if (ts_e) begin
      m_work = m_comm;
    end else if (sv_r) begin
      if (work_value() == 0) m_reject = 1'b1;
      else begin
        m_comm     = m_work;
        m_pend_val = work_value();
        m_pend_cnt = 4;
        m_valid    = 1'b0;
      end
    end else if (ed_r && edit_mode && tp_selected <= 3'd3) begin
      s = int'(tp_selected);
      d = int'(m_work[s]);
      if (d > 9)       nd = 0;
      else if (tp_adj) nd = (d + 1) % 10;
      else             nd = (d + 9) % 10;
      m_work[s] = 4'(nd);
    end

    if (!edit_mode)    m_ticks = 0;
    else if (timebase) m_ticks++;

    p_ts = tp_temp_sync; p_sv = tp_save; p_ed = tp_edit_enable;
  endtask

  task automatic compare_all();
    logic [3:0] exp_blank;
    exp_blank = 4'b0000;
    if (edit_mode && tp_selected <= 3'd3 && ((m_ticks / 250) % 2) == 1)
      exp_blank = 4'(1 << tp_selected);
    check("work_bcd",      32'(work_bcd),      32'({m_work[3], m_work[2], m_work[1], m_work[0]}));
    check("period_ms",     32'(period_ms),     32'(m_period));
    check("period_valid",  32'(period_valid),  32'(m_valid));
    check("commit_reject", 32'(commit_reject), 32'(m_reject));
    check("blank_mask",    32'(blank_mask),    32'(exp_blank));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #2;
      if (m_live) compare_all();
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic strobe_edit(input logic [2:0] sel, input logic inc);
    tp_selected = sel; tp_adj = inc; tp_edit_enable = 1'b1;
    @(negedge clk);
    tp_edit_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe_sync();
    tp_temp_sync = 1'b1;
    @(negedge clk);
    tp_temp_sync = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; timebase = 1'b0; edit_mode = 1'b0; tp_selected = 3'd0;
    tp_adj = 1'b0; tp_edit_enable = 1'b0; tp_save = 1'b1; tp_temp_sync = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_period_ms", 32'(period_ms),    32'd100);
    check("rst_valid",     32'(period_valid), 32'd1);
    check("rst_work",      32'(work_bcd),     32'h0100);
    check("rst_blank",     32'(blank_mask),   32'd0);
    tp_save = 1'b0; tp_temp_sync = 1'b0;
    @(negedge clk);

    // Increment d0 three times, then commit 0103.
    strobe_sync();
    edit_mode = 1'b1;
    repeat (3) strobe_edit(3'd0, 1'b1);
    check("inc3_work", 32'(work_bcd), 32'h0103);
    tp_save = 1'b1;
    @(negedge clk);
    tp_save = 1'b0;
    check("save_valid_low", 32'(period_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("conv_last_busy", 32'(period_valid), 32'd0);
    check("conv_old_period", 32'(period_ms), 32'd100);
    @(negedge clk);
    check("conv_valid", 32'(period_valid), 32'd1);
    check("conv_period_103", 32'(period_ms), 32'd103);

    // Digit wrap without carry/borrow.
    repeat (2) strobe_edit(3'd1, 1'b1);
    repeat (6) strobe_edit(3'd0, 1'b1);
    check("d0_at_9", 32'(work_bcd), 32'h0129);
    strobe_edit(3'd0, 1'b1);
    check("inc_wrap", 32'(work_bcd), 32'h0120);
    strobe_edit(3'd3, 1'b0);
    check("dec_wrap", 32'(work_bcd), 32'h9120);

    // Ignored edits: selection out of range, and outside edit mode.
    strobe_edit(3'd5, 1'b1);
    check("sel_out_of_range", 32'(work_bcd), 32'h9120);
    edit_mode = 1'b0;
    strobe_edit(3'd0, 1'b1);
    check("edit_mode_off", 32'(work_bcd), 32'h9120);
    edit_mode = 1'b1;

    // Commit of 0000 is refused.
    strobe_sync();
    check("sync_reload", 32'(work_bcd), 32'h0103);
    repeat (3) strobe_edit(3'd0, 1'b0);
    strobe_edit(3'd2, 1'b0);
    check("work_zero", 32'(work_bcd), 32'h0000);
    tp_save = 1'b1;
    @(negedge clk);
    tp_save = 1'b0;
    check("reject_pulse", 32'(commit_reject), 32'd1);
    check("reject_valid", 32'(period_valid),  32'd1);
    @(negedge clk);
    check("reject_end", 32'(commit_reject), 32'd0);
    check("reject_period", 32'(period_ms), 32'd103);

    // temp_sync and edit together: edit is lost.
    tp_temp_sync = 1'b1; tp_edit_enable = 1'b1; tp_selected = 3'd0; tp_adj = 1'b1;
    @(negedge clk);
    tp_temp_sync = 1'b0; tp_edit_enable = 1'b0;
    @(negedge clk);
    check("sync_beats_edit", 32'(work_bcd), 32'h0103);

    // Two saves two cycles apart: only the second value is output.
    strobe_edit(3'd0, 1'b1);
    tp_save = 1'b1;
    @(negedge clk);
    tp_save = 1'b0; tp_selected = 3'd0; tp_adj = 1'b1; tp_edit_enable = 1'b1;
    @(negedge clk);
    tp_edit_enable = 1'b0; tp_save = 1'b1;
    @(negedge clk);
    tp_save = 1'b0;
    repeat (3) @(negedge clk);
    check("restart_busy", 32'(period_valid), 32'd0);
    check("restart_hold", 32'(period_ms), 32'd103);
    @(negedge clk);
    check("restart_valid", 32'(period_valid), 32'd1);
    check("restart_period", 32'(period_ms), 32'd105);

    // Asynchronous reset in the middle of a conversion.
    strobe_edit(3'd0, 1'b1);
    tp_save = 1'b1;
    @(negedge clk);
    tp_save = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_period", 32'(period_ms),    32'd100);
    check("midrst_valid",  32'(period_valid), 32'd1);
    check("midrst_work",   32'(work_bcd),     32'h0100);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Blink: tick every cycle, selected digit 2.
    edit_mode = 1'b0;
    @(negedge clk);
    edit_mode = 1'b1; tp_selected = 3'd2; timebase = 1'b1;
    repeat (249) @(negedge clk);
    check("blink_249", 32'(blank_mask), 32'h0);
    @(negedge clk);
    check("blink_250", 32'(blank_mask), 32'h4);
    repeat (249) @(negedge clk);
    check("blink_499", 32'(blank_mask), 32'h4);
    @(negedge clk);
    check("blink_500", 32'(blank_mask), 32'h0);
    repeat (500) @(negedge clk);
    check("blink_1000", 32'(blank_mask), 32'h0);
    repeat (250) @(negedge clk);
    check("blink_1250", 32'(blank_mask), 32'h4);
    edit_mode = 1'b0;
    #1;
    check("blink_exit", 32'(blank_mask), 32'h0);
    @(negedge clk);
    edit_mode = 1'b1;
    @(negedge clk);
    check("blink_reenter", 32'(blank_mask), 32'h0);
    timebase = 1'b0; edit_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
